enable_sequencer: RTL and testbench
===================================

Name: enable_sequencer

Overview:
- Staged power-up/power-down controller for gated enables: releases NUM_STAGES enables strictly in order, each after a programmable delay counted in timebase ticks, and waits for each stage's ready before starting the next.
- Shuts enables down in reverse order.
- Sits between the system controller and the delay-gated subsystems; tick_i comes from the real-time timebase, already synchronized to clk_i.

Parameters:
- NUM_STAGES, 4, number of sequenced enables (>=2).
- CNT_W, 16, width of delay/timeout fields and tick counter.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset; synchronous, active-low
- tick_i  input  1  single-cycle timebase pulse, synchronous to clk_i
- start_i  input  1  level; begin power-up sequence
- stop_i  input  1  level; begin power-down / abort / clear error
- delay_i  input  NUM_STAGES*CNT_W  per-stage delay in ticks; stage k at bits [k*CNT_W +: CNT_W]
- stage_ready_i  input  NUM_STAGES  per-stage ready acknowledge
- timeout_i  input  CNT_W  ready timeout in ticks; 0 = no timeout (only with ENSEQ_TIMEOUT_EN)
- enable_o  output  NUM_STAGES  sequenced enables
- busy_o  output  1  sequence in progress (WAIT_DLY, WAIT_RDY, DOWN)
- done_o  output  1  all stages enabled and ready (state UP)
- error_o  output  1  stage failed to report ready (only with ENSEQ_TIMEOUT_EN)
- err_stage_o  output  $clog2(NUM_STAGES)  index of failing stage (only with ENSEQ_TIMEOUT_EN)

Behaviour:
- Reset (rst_ni low at clk_i edge):
  - state=IDLE, stage index k=0, tick counter=0.
  - All outputs 0.
- States: IDLE, WAIT_DLY, WAIT_RDY, UP, DOWN, ERROR. All outputs are registered.
- IDLE:
  - start_i=1 and stop_i=0 -> WAIT_DLY, k=0, counter cleared.
  - If start_i and stop_i are both high, stop wins: remain in IDLE.
- WAIT_DLY:
  - Counter increments on tick_i and saturates at all-ones.
  - When counter==delay[k], go to WAIT_RDY and set enable_o[k]=1 on the same edge.
  - delay[k]=0 means one clk_i cycle in WAIT_DLY.
  - delay_i is sampled live; the team guarantees it is static while busy_o=1.
- WAIT_RDY:
  - Counter is cleared on entry.
  - stage_ready_i[k]=1 -> if k==NUM_STAGES-1, go to UP; else k++ and go to WAIT_DLY.
  - A ready that is already high on entry is accepted on the first WAIT_RDY cycle.
- UP:
  - done_o=1 and enable_o all ones.
  - stop_i -> DOWN with k=NUM_STAGES-1; start_i is ignored.
  - Loss of stage_ready_i while in UP is ignored.
- stop_i in WAIT_DLY or WAIT_RDY aborts the sequence:
  - Go to DOWN at the current k.
  - In WAIT_DLY, enable_o[k] is not yet set, so DOWN begins at k-1. If k==0, go straight to IDLE.
- DOWN:
  - Clear enable_o[k] on entry to each stage.
  - Wait delay[k] ticks, then k--.
  - After stage 0 is cleared and its delay has elapsed, go to IDLE.
  - start_i is ignored in DOWN; a new sequence needs IDLE.
- Latencies:
  - start_i to enable_o[0] = delay[0] ticks plus 2 clk_i cycles.
  - stop_i to first enable deassert = 1 clk_i cycle.
- Counter width: exactly CNT_W bits with saturating arithmetic; it never wraps.
- Reset mid-sequence: all enables drop on the next clk_i edge. No ordered shutdown is guaranteed.

Optional Feature:
- ENSEQ_TIMEOUT_EN defined:
  - timeout_i, error_o and err_stage_o ports exist.
  - In WAIT_RDY, if timeout_i!=0 and counter==timeout_i, go to ERROR.
  - On that edge: clear all enable_o simultaneously, set error_o=1, err_stage_o=k.
  - ERROR holds until stop_i=1, then IDLE with error_o and err_stage_o cleared.
- Undefined: the ports and the ERROR state are absent, and WAIT_RDY waits indefinitely.

Decomposition:
- Package enable_seq_pkg: state enum typedef enable_seq_state_e, default CNT_W constant, helper localparam for the stage index width.
- One sub-module, seq_tick_counter:
  - CNT_W-bit saturating tick counter.
  - Inputs: clear, tick, compare value. Output: match flag.
  - Used for both delay and timeout.

Test Plan:
- NUM_STAGES=4, delays {3,0,5,2}, ready tied high, tick every 4 clk_i -> enable_o sets stages 0..3 in order. Stage 0 after 3 ticks, stage 1 two clk_i later, done_o=1 after stage 3 is ready.
- In UP, pulse stop_i -> enables clear 3,2,1,0 separated by delays 2,5,0,3 ticks. IDLE after stage 0 delay. busy_o=1 throughout.
- Hold stage_ready_i[1]=0, assert stop_i in WAIT_RDY k=1 -> enable_o[1] clears next cycle, then enable_o[0]. Return to IDLE; done_o never set.
- start_i and stop_i high together in IDLE -> stays in IDLE, enable_o=0.
- ENSEQ_TIMEOUT_EN, timeout_i=4, stage_ready_i[2] stuck 0 -> after 4 ticks in WAIT_RDY: enable_o=0, error_o=1, err_stage_o=2. stop_i clears to IDLE.
- rst_ni low for 1 cycle while in WAIT_RDY k=2 -> all outputs 0 next edge. A fresh start_i restarts from stage 0.

Source files
------------

// File: rtl/enable_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : enable_seq_pkg
//  Purpose  : Shared types and constants for the staged enable sequencer:
//             FSM state encoding, default counter width and the helper that
//             sizes the stage index.
//  Ports    : none (package)
//  Config   : ENSEQ_TIMEOUT_EN makes ST_ERROR reachable in enable_sequencer
//  Revision : 1.0 - initial release
// ============================================================================
package enable_seq_pkg;

    localparam int DEFAULT_CNT_W      = 16;
    localparam int DEFAULT_NUM_STAGES = 4;

    // Width of a stage index; never narrower than one bit.
    function automatic int stage_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEFAULT_IDX_W = stage_idx_w(DEFAULT_NUM_STAGES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_DLY = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_UP       = 3'd3,
        ST_DOWN     = 3'd4,
        ST_ERROR    = 3'd5
    } enable_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/enable_sequencer_seq_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module   : seq_tick_counter
//  Purpose  : Saturating timebase-tick counter with equality compare. Shared
//             by the stage delay and the ready timeout.
//  Ports    : clk     - system clock
//             rst_n   - synchronous active-low reset
//             clear   - zero the count (wins over tick)
//             tick    - single-cycle timebase pulse
//             compare - value the count is matched against
//             match   - count equals compare (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_tick_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] compare,
    output logic             match
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != {CNT_W{1'b1}})) begin
            // Holds at all-ones instead of wrapping back to a small value.
            count <= count + 1'b1;
        end
    end

    assign match = (count == compare);

endmodule
`default_nettype wire

// File: rtl/enable_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : enable_sequencer
//  Purpose  : Staged power-up / power-down controller. Releases NUM_STAGES
//             enables in order, each after a per-stage tick delay and only
//             once the previous stage reports ready; shuts down in reverse.
//  Ports    : clk_i         - system clock
//             rst_ni        - synchronous active-low reset
//             tick_i        - timebase pulse, synchronous to clk_i
//             start_i       - level, begin power-up
//             stop_i        - level, power-down / abort / clear error
//             delay_i       - per-stage delay, stage k at [k*CNT_W +: CNT_W]
//             stage_ready_i - per-stage ready acknowledge
//             timeout_i     - ready timeout in ticks, 0 disables
//             enable_o      - sequenced enables
//             busy_o        - sequencing or shutting down
//             done_o        - all stages enabled and ready
//             error_o       - a stage failed to report ready
//             err_stage_o   - index of the failing stage
//  Config   : ENSEQ_TIMEOUT_EN adds timeout_i, error_o, err_stage_o and the
//             ERROR state; without it WAIT_RDY waits indefinitely.
//  Revision : 1.0 - initial release
// ============================================================================
module enable_sequencer
    import enable_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
    parameter int CNT_W      = DEFAULT_CNT_W,
    localparam int IDX_W     = stage_idx_w(NUM_STAGES)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        tick_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic [NUM_STAGES*CNT_W-1:0] delay_i,
    input  logic [NUM_STAGES-1:0]       stage_ready_i,
    output logic [NUM_STAGES-1:0]       enable_o,
    output logic                        busy_o,
    output logic                        done_o
`ifdef ENSEQ_TIMEOUT_EN
    ,
    input  logic [CNT_W-1:0]            timeout_i,
    output logic                        error_o,
    output logic [IDX_W-1:0]            err_stage_o
`endif
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(NUM_STAGES - 1);

    enable_seq_state_e state;
    logic [IDX_W-1:0]  k;
    logic [IDX_W-1:0]  k_dec;
    logic [CNT_W-1:0]  dly_arr [NUM_STAGES];
    logic [CNT_W-1:0]  dly_k;
    logic [CNT_W-1:0]  cmp_val;
    logic              rdy_k;
    logic              cnt_clear;
    logic              cnt_match;
    logic              tmo_hit;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_dly_unpack
        assign dly_arr[i] = delay_i[i*CNT_W +: CNT_W];
    end

    assign dly_k = dly_arr[k];
    assign rdy_k = stage_ready_i[k];
    assign k_dec = k - 1'b1;

`ifdef ENSEQ_TIMEOUT_EN
    // One counter serves both jobs: it times the ready wait in WAIT_RDY and
    // the stage delay everywhere else.
    assign cmp_val = (state == ST_WAIT_RDY) ? timeout_i : dly_k;
    assign tmo_hit = (timeout_i != '0) && cnt_match;
`else
    assign cmp_val = dly_k;
    assign tmo_hit = 1'b0;
`endif

    // The counter must restart from zero on every edge that moves to a new
    // state or stage, so that a delay of 0 spends exactly one cycle waiting.
    always_comb begin
        cnt_clear = 1'b1;
        case (state)
            ST_WAIT_DLY: cnt_clear = stop_i || cnt_match;
            ST_WAIT_RDY: cnt_clear = stop_i || rdy_k || tmo_hit;
            ST_DOWN:     cnt_clear = cnt_match;
            default:     cnt_clear = 1'b1;
        endcase
    end

    seq_tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clear   (cnt_clear),
        .tick    (tick_i),
        .compare (cmp_val),
        .match   (cnt_match)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            k        <= '0;
            enable_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
`ifdef ENSEQ_TIMEOUT_EN
            error_o     <= 1'b0;
            err_stage_o <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        state  <= ST_WAIT_DLY;
                        k      <= '0;
                        busy_o <= 1'b1;
                    end
                end

                ST_WAIT_DLY: begin
                    if (stop_i) begin
                        // enable_o[k] is not on yet: shutdown starts below k.
                        if (k == '0) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state           <= ST_DOWN;
                            k               <= k_dec;
                            enable_o[k_dec] <= 1'b0;
                        end
                    end else if (cnt_match) begin
                        state       <= ST_WAIT_RDY;
                        enable_o[k] <= 1'b1;
                    end
                end

                ST_WAIT_RDY: begin
                    if (stop_i) begin
                        state       <= ST_DOWN;
                        enable_o[k] <= 1'b0;
                    end else if (rdy_k) begin
                        if (k == LAST_K) begin
                            state  <= ST_UP;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_WAIT_DLY;
                            k     <= k + 1'b1;
                        end
                    end
`ifdef ENSEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state       <= ST_ERROR;
                        enable_o    <= '0;
                        busy_o      <= 1'b0;
                        error_o     <= 1'b1;
                        err_stage_o <= k;
                    end
`endif
                end

                ST_UP: begin
                    if (stop_i) begin
                        state            <= ST_DOWN;
                        k                <= LAST_K;
                        enable_o[LAST_K] <= 1'b0;
                        busy_o           <= 1'b1;
                        done_o           <= 1'b0;
                    end
                end

                ST_DOWN: begin
                    if (cnt_match) begin
                        if (k == '0) begin
                            state  <= ST_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            k               <= k_dec;
                            enable_o[k_dec] <= 1'b0;
                        end
                    end
                end

`ifdef ENSEQ_TIMEOUT_EN
                ST_ERROR: begin
                    if (stop_i) begin
                        state       <= ST_IDLE;
                        error_o     <= 1'b0;
                        err_stage_o <= '0;
                    end
                end
`endif

                default: begin
                    state    <= ST_IDLE;
                    k        <= '0;
                    enable_o <= '0;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enable_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enable_sequencer
//  Purpose  : Self-checking bench for enable_sequencer. Every clock edge is
//             logged (tick applied, outputs after the edge); expected edge
//             numbers are derived from the tick log using the sequencing
//             rules: a stage event happens on the first edge after `delay`
//             ticks have been seen on the edges following stage entry.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enable_sequencer;

    localparam int NS     = 4;
    localparam int CW     = 16;
    localparam int IW     = 2;
    localparam int LOGN   = 4096;
    localparam int BUDGET = 1500;

    logic            clk    = 1'b0;
    logic            rst_ni = 1'b0;
    logic            tick   = 1'b0;
    logic            start  = 1'b0;
    logic            stop   = 1'b0;
    logic [NS*CW-1:0] delay_v = '0;
    logic [NS-1:0]   ready  = '0;
    logic [NS-1:0]   enable;
    logic            busy;
    logic            done;
`ifdef ENSEQ_TIMEOUT_EN
    logic [CW-1:0]   timeout = '0;
    logic            error;
    logic [IW-1:0]   err_stage;
`endif

    int checks = 0;
    int errors = 0;

    int        dly [NS];
    int        ecount;
    int        tick_mode;
    int        tick_phase;
    logic      tick_log [LOGN];
    logic [NS-1:0] en_log [LOGN];
    logic      busy_log [LOGN];
    logic      done_log [LOGN];

    enable_sequencer #(
        .NUM_STAGES (NS),
        .CNT_W      (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .tick_i        (tick),
        .start_i       (start),
        .stop_i        (stop),
        .delay_i       (delay_v),
        .stage_ready_i (ready),
        .enable_o      (enable),
        .busy_o        (busy),
        .done_o        (done)
`ifdef ENSEQ_TIMEOUT_EN
        ,
        .timeout_i     (timeout),
        .error_o       (error),
        .err_stage_o   (err_stage)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge; outputs sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (ecount < LOGN) begin
            tick_log[ecount] = tick;
            en_log[ecount]   = enable;
            busy_log[ecount] = busy;
            done_log[ecount] = done;
        end
        ecount++;
    endtask

    // mode 0: no ticks, 1: every 4th clock, 2: random ~1 in 4
    task automatic drive_tick();
        case (tick_mode)
            1:       tick = ((tick_phase % 4) == 3);
            2:       tick = ($urandom_range(0, 3) == 0);
            default: tick = 1'b0;
        endcase
        tick_phase++;
    endtask

    task automatic step();
        drive_tick();
        cycle();
    endtask

    task automatic set_delays();
        for (int i = 0; i < NS; i++) delay_v[i*CW +: CW] = CW'(dly[i]);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
        cycle(); cycle();
        rst_ni = 1'b1;
        ecount = 0; tick_phase = 0;
    endtask

    // First edge after `entry` at which `d` ticks (on edges entry+1..e-1)
    // have been counted.
    function automatic int next_event(input int entry, input int d);
        int acc = 0;
        if (entry < 0) return -2;
        for (int e = entry + 1; e < LOGN; e++) begin
            if (acc >= d) return e;
            if (e >= ecount) return e;
            acc += int'(tick_log[e]);
        end
        return -3;
    endfunction

    function automatic int find_en(input int b, input logic v, input int from);
        for (int e = from; e < ecount && e < LOGN; e++)
            if (e >= 0 && en_log[e][b] === v) return e;
        return -1;
    endfunction

    function automatic int find_busy(input logic v, input int from);
        for (int e = from; e < ecount && e < LOGN; e++)
            if (e >= 0 && busy_log[e] === v) return e;
        return -1;
    endfunction

    function automatic int find_done(input logic v, input int from);
        for (int e = from; e < ecount && e < LOGN; e++)
            if (e >= 0 && done_log[e] === v) return e;
        return -1;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0; start = 1'b1; stop = 1'b0; ready = '1;
        cycle(); cycle();
        checks++;
        if (enable !== '0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef ENSEQ_TIMEOUT_EN
        checks++;
        if (error !== 1'b0 || err_stage !== '0) begin
            errors++; $display("FAIL reset_error: got %b/%0d expected 0/0", error, err_stage);
        end
`endif
        start = 1'b0;
    endtask

    // Full power-up, ready drop in UP, then full power-down.
    task automatic test_sequence(input string name, input int mode);
        int act, exp, entry, t, n;
        bit ok;
        do_reset();
        set_delays();
        ready = '1; tick_mode = mode;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < BUDGET) begin step(); n++; end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL %s_up_budget: done=%b expected 1", name, done); end

        entry = 0;
        for (int k = 0; k < NS; k++) begin
            exp = next_event(entry, dly[k]);
            act = find_en(k, 1'b1, 0);
            checks++;
            if (act !== exp) begin
                errors++; $display("FAIL %s_rise%0d: edge %0d expected %0d", name, k, act, exp);
            end
            entry = exp + 1;
        end
        act = find_done(1'b1, 0);
        checks++;
        if (act !== entry) begin errors++; $display("FAIL %s_done_edge: edge %0d expected %0d", name, act, entry); end
        ok = (entry < ecount) && (busy_log[entry] === 1'b0);
        for (int e = 0; e < entry && e < LOGN; e++) if (busy_log[e] !== 1'b1) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_busy_up: got %b expected 1", name, ok); end

        // Ready loss and start are both ignored while UP.
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            ready = NS'($urandom); start = 1'b1;
            step();
            if (done !== 1'b1 || enable !== '1) ok = 0;
        end
        ready = '1; start = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_up_hold: got %b expected 1", name, ok); end

        t = ecount;
        stop = 1'b1; step(); stop = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin step(); n++; end
        act = find_en(NS - 1, 1'b0, t);
        checks++;
        if (act !== t) begin errors++; $display("FAIL %s_fall%0d: edge %0d expected %0d", name, NS - 1, act, t); end
        entry = t;
        for (int k = NS - 1; k >= 0; k--) begin
            exp = next_event(entry, dly[k]);
            if (k > 0) begin
                act = find_en(k - 1, 1'b0, t);
                checks++;
                if (act !== exp) begin
                    errors++; $display("FAIL %s_fall%0d: edge %0d expected %0d", name, k - 1, act, exp);
                end
            end
            entry = exp;
        end
        act = find_busy(1'b0, t);
        checks++;
        if (act !== entry) begin errors++; $display("FAIL %s_idle_edge: edge %0d expected %0d", name, act, entry); end
        ok = (t < LOGN) && (done_log[t] === 1'b0);
        for (int e = t; e < entry && e < LOGN; e++) if (busy_log[e] !== 1'b1) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s_busy_down: got %b expected 1", name, ok); end
        checks++;
        if (enable !== '0) begin errors++; $display("FAIL %s_final_enable: got %b expected 0", name, enable); end
    endtask

    // Stage 1 never ready; stop while waiting on it.
    task automatic test_abort_wait_rdy();
        int act, exp0, exp_idle, t, n;
        bit ok;
        do_reset();
        for (int i = 0; i < NS; i++) dly[i] = $urandom_range(0, 5);
        set_delays();
        ready = 4'b1101; tick_mode = 2;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (enable[1] !== 1'b1 && n < BUDGET) begin step(); n++; end
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) step();
        t = ecount;
        stop = 1'b1; step(); stop = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin step(); n++; end
        act = find_en(1, 1'b0, t);
        checks++;
        if (act !== t) begin errors++; $display("FAIL abort_fall1: edge %0d expected %0d", act, t); end
        exp0 = next_event(t, dly[1]);
        act = find_en(0, 1'b0, t);
        checks++;
        if (act !== exp0) begin errors++; $display("FAIL abort_fall0: edge %0d expected %0d", act, exp0); end
        exp_idle = next_event(exp0, dly[0]);
        act = find_busy(1'b0, t);
        checks++;
        if (act !== exp_idle) begin errors++; $display("FAIL abort_idle: edge %0d expected %0d", act, exp_idle); end
        ok = 1;
        for (int e = 0; e < ecount && e < LOGN; e++)
            if (done_log[e] !== 1'b0 || en_log[e][2] !== 1'b0) ok = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_no_progress: got %b expected 1", ok); end
    endtask

    // Stop during stage-0 delay returns straight to IDLE.
    task automatic test_abort_wait_dly0();
        do_reset();
        dly[0] = 20; dly[1] = 1; dly[2] = 1; dly[3] = 1;
        set_delays();
        ready = '1; tick_mode = 0;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        checks++;
        if (busy !== 1'b1 || enable !== '0) begin
            errors++; $display("FAIL dly0_waiting: busy=%b enable=%b expected 1/0000", busy, enable);
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || enable !== '0) begin
            errors++; $display("FAIL dly0_abort: busy=%b enable=%b expected 0/0000", busy, enable);
        end
    endtask

    task automatic test_start_stop_together();
        do_reset();
        dly = '{0, 0, 0, 0};
        set_delays();
        ready = '1; tick_mode = 2;
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b0 || enable !== '0) begin
                errors++; $display("FAIL start_stop_%0d: busy=%b enable=%b expected 0/0000", i, busy, enable);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    // Reset while waiting on stage 2, then a clean restart.
    task automatic test_reset_mid();
        int n, exp, act;
        do_reset();
        for (int i = 0; i < NS; i++) dly[i] = $urandom_range(0, 4);
        set_delays();
        ready = 4'b1011; tick_mode = 2;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (enable[2] !== 1'b1 && n < BUDGET) begin step(); n++; end
        step(); step();
        checks++;
        if (enable !== 4'b0111) begin errors++; $display("FAIL rstmid_pre: enable=%b expected 0111", enable); end
        rst_ni = 1'b0; step(); rst_ni = 1'b1;
        checks++;
        if (enable !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear: enable=%b busy=%b done=%b expected 0", enable, busy, done);
        end
        ready = '1; ecount = 0;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (enable === '0 && n < BUDGET) begin step(); n++; end
        checks++;
        if (enable !== 4'b0001) begin errors++; $display("FAIL rstmid_restart: enable=%b expected 0001", enable); end
        exp = next_event(0, dly[0]);
        act = find_en(0, 1'b1, 0);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL rstmid_rise0: edge %0d expected %0d", act, exp); end
    endtask

`ifdef ENSEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n, r, exp, act;
        do_reset();
        for (int i = 0; i < NS; i++) dly[i] = $urandom_range(0, 4);
        set_delays();
        ready = 4'b1011; tick_mode = 2; timeout = 16'd4;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (error !== 1'b1 && n < BUDGET) begin step(); n++; end
        act = ecount - 1;
        r = find_en(2, 1'b1, 0);
        exp = next_event(r, 4);
        checks++;
        if (act !== exp) begin errors++; $display("FAIL timeout_edge: edge %0d expected %0d", act, exp); end
        checks++;
        if (enable !== '0 || error !== 1'b1 || err_stage !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: enable=%b error=%b stage=%0d busy=%b expected 0000/1/2/0",
                     enable, error, err_stage, busy);
        end
        step(); step();
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL timeout_hold: error=%b expected 1", error); end
        stop = 1'b1; step(); stop = 1'b0;
        checks++;
        if (error !== 1'b0 || err_stage !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: error=%b stage=%0d expected 0/0", error, err_stage);
        end
        timeout = '0;
    endtask
`endif

    initial begin
        ecount = 0; tick_mode = 0; tick_phase = 0;
        test_reset();
        dly = '{3, 0, 5, 2};
        test_sequence("directed", 1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NS; i++) dly[i] = $urandom_range(0, 6);
            test_sequence($sformatf("rand%0d", r), 2);
        end
        test_abort_wait_rdy();
        test_abort_wait_dly0();
        test_start_stop_together();
        test_reset_mid();
`ifdef ENSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
